// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit AXI4-Lite master: state encoding,
// RV64 load/store funct3 codes and AXI response codes.
package lsu_pkg;

    localparam int XLEN = 64;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_RADDR = 3'd1;
    localparam state_t S_RDATA = 3'd2;
    localparam state_t S_WREQ  = 3'd3;
    localparam state_t S_WRESP = 3'd4;
    localparam state_t S_DONE  = 3'd5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Low address bits that must be zero for a naturally aligned access of 2**size bytes.
    function automatic logic [2:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    size_mask = 3'b000;
            2'd1:    size_mask = 3'b001;
            2'd2:    size_mask = 3'b011;
            default: size_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_axi_master_if.sv
// AXI4-Lite bus bundle between the LSU master and its memory slave.
interface lsu_axi_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, input arready,
        input rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready
    );

    modport slave (
        input araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input awaddr, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension, store shift and strobes,
// and detection of misaligned or illegal accesses.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      offset,
    input  logic [2:0]      funct3,
    input  logic            is_load,
    input  logic [XLEN-1:0] rdata,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] wdata,
    output logic [7:0]      wstrb,
    output logic            err
);
    logic [XLEN-1:0] lane;
    logic [7:0]      strb_base;
    logic            illegal;
    logic            misaligned;

    always_comb begin
        lane = rdata >> {offset, 3'b000};
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{56{lane[7]}}, lane[7:0]};
            F3_H:    load_data = {{48{lane[15]}}, lane[15:0]};
            F3_W:    load_data = {{32{lane[31]}}, lane[31:0]};
            F3_D:    load_data = lane;
            F3_BU:   load_data = {56'd0, lane[7:0]};
            F3_HU:   load_data = {48'd0, lane[15:0]};
            F3_WU:   load_data = {32'd0, lane[31:0]};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        case (funct3[1:0])
            2'd0:    strb_base = 8'h01;
            2'd1:    strb_base = 8'h03;
            2'd2:    strb_base = 8'h0F;
            default: strb_base = 8'hFF;
        endcase
        wstrb = strb_base << offset;
        wdata = store_data << {offset, 3'b000};
    end

    // Loads only reject funct3=111; stores only know the four signed sizes.
    assign illegal    = is_load ? (funct3 == 3'b111) : funct3[2];
    assign misaligned = (offset & size_mask(funct3[1:0])) != 3'b000;
    assign err        = illegal | misaligned;

endmodule

// File: rtl/lsu_axi_master.sv
// Load/store unit bus master: turns one MEM-stage load or store request into a
// single AXI4-Lite transaction and reports completion with a one-cycle pulse.
module lsu_axi_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lsu_r_ready,
    input  logic                lsu_w_valid,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_w_data,
    input  logic [2:0]          lsu_funct3,
    output logic                lsu_idle,
    output logic                lsu_r_valid,
    output logic [DATA_W-1:0]   lsu_r_data,
    output logic                lsu_w_ready,
    output logic                lsu_err,
    lsu_axi_master_if.master    axi
);
    state_t            state;
    logic              is_load_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic [DATA_W-1:0] w_data_q;
    logic              aw_done;
    logic              w_done;

    logic              in_idle;
    logic [2:0]        offset_sel;
    logic [2:0]        funct3_sel;
    logic              is_load_sel;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] shifted_wdata;
    logic [7:0]        shifted_wstrb;
    logic              req_err;
    logic              aw_fire;
    logic              w_fire;

    // In IDLE the aligner checks the incoming request; afterwards it works on the latched one.
    assign in_idle     = (state == S_IDLE);
    assign offset_sel  = in_idle ? lsu_addr[2:0] : addr_q[2:0];
    assign funct3_sel  = in_idle ? lsu_funct3 : funct3_q;
    assign is_load_sel = in_idle ? lsu_r_ready : is_load_q;

    lsu_align u_align (
        .offset     (offset_sel),
        .funct3     (funct3_sel),
        .is_load    (is_load_sel),
        .rdata      (axi.rdata),
        .store_data (w_data_q),
        .load_data  (load_data),
        .wdata      (shifted_wdata),
        .wstrb      (shifted_wstrb),
        .err        (req_err)
    );

    assign aw_fire = axi.awvalid & axi.awready;
    assign w_fire  = axi.wvalid & axi.wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            is_load_q  <= 1'b0;
            addr_q     <= '0;
            funct3_q   <= '0;
            w_data_q   <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            lsu_err    <= 1'b0;
            lsu_r_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (lsu_r_ready || lsu_w_valid) begin
                        is_load_q <= lsu_r_ready;
                        addr_q    <= lsu_addr;
                        funct3_q  <= lsu_funct3;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        if (!lsu_r_ready) begin
                            w_data_q <= lsu_w_data;
                        end
                        // Bad accesses never reach the bus and complete with an error.
                        if (req_err) begin
                            lsu_err <= 1'b1;
                            state   <= S_DONE;
                            if (lsu_r_ready) begin
                                lsu_r_data <= '0;
                            end
                        end else begin
                            lsu_err <= 1'b0;
                            state   <= lsu_r_ready ? S_RADDR : S_WREQ;
                        end
                    end
                end
                S_RADDR: begin
                    if (axi.arready) begin
                        state <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (axi.rvalid) begin
                        lsu_r_data <= load_data;
                        lsu_err    <= (axi.rresp != RESP_OKAY);
                        state      <= S_DONE;
                    end
                end
                S_WREQ: begin
                    if (aw_fire) begin
                        aw_done <= 1'b1;
                    end
                    if (w_fire) begin
                        w_done <= 1'b1;
                    end
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        state <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (axi.bvalid) begin
                        lsu_err <= (axi.bresp != RESP_OKAY);
                        state   <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign lsu_idle    = in_idle;
    assign lsu_r_valid = (state == S_DONE) && is_load_q;
    assign lsu_w_ready = (state == S_DONE) && !is_load_q;

    assign axi.araddr  = {addr_q[ADDR_W-1:3], 3'b000};
    assign axi.arvalid = (state == S_RADDR);
    assign axi.rready  = (state == S_RDATA);
    assign axi.awaddr  = {addr_q[ADDR_W-1:3], 3'b000};
    assign axi.awvalid = (state == S_WREQ) && !aw_done;
    assign axi.wvalid  = (state == S_WREQ) && !w_done;
    assign axi.wdata   = shifted_wdata;
    assign axi.wstrb   = shifted_wstrb;
    assign axi.bready  = (state == S_WRESP);

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: the bench plays the AXI slave by hand and
// checks every expected value at fixed cycle offsets from each request.
module tb_lsu_axi_master;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_r_ready;
    logic        lsu_w_valid;
    logic [31:0] lsu_addr;
    logic [63:0] lsu_w_data;
    logic [2:0]  lsu_funct3;
    logic        lsu_idle;
    logic        lsu_r_valid;
    logic [63:0] lsu_r_data;
    logic        lsu_w_ready;
    logic        lsu_err;

    int tests_run    = 0;
    int tests_failed = 0;

    lsu_axi_master_if #(.ADDR_W(32), .DATA_W(64)) axi ();

    lsu_axi_master #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .lsu_r_ready (lsu_r_ready),
        .lsu_w_valid (lsu_w_valid),
        .lsu_addr    (lsu_addr),
        .lsu_w_data  (lsu_w_data),
        .lsu_funct3  (lsu_funct3),
        .lsu_idle    (lsu_idle),
        .lsu_r_valid (lsu_r_valid),
        .lsu_r_data  (lsu_r_data),
        .lsu_w_ready (lsu_w_ready),
        .lsu_err     (lsu_err),
        .axi         (axi.master)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                  input logic [63:0] data, input logic [2:0] f3);
        lsu_r_ready = rd;
        lsu_w_valid = wr;
        lsu_addr    = addr;
        lsu_w_data  = data;
        lsu_funct3  = f3;
    endtask

    initial begin
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, 32'h0, 64'h0, 3'b000);
        axi.arready = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = RESP_OKAY;
        axi.rvalid  = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bresp   = RESP_OKAY;
        axi.bvalid  = 1'b0;
        tick();
        tick();

        check_output("rst_idle", 64'(lsu_idle), 64'd1);
        check_output("rst_arvalid", 64'(axi.arvalid), 64'd0);
        check_output("rst_awvalid", 64'(axi.awvalid), 64'd0);
        check_output("rst_wvalid", 64'(axi.wvalid), 64'd0);
        check_output("rst_rready", 64'(axi.rready), 64'd0);
        check_output("rst_bready", 64'(axi.bready), 64'd0);
        check_output("rst_r_valid", 64'(lsu_r_valid), 64'd0);
        check_output("rst_w_ready", 64'(lsu_w_ready), 64'd0);
        check_output("rst_err", 64'(lsu_err), 64'd0);
        check_output("rst_r_data", lsu_r_data, 64'd0);
        rst = 1'b0;
        tick();

        // LW 0x80000004 with an always-ready slave
        axi.arready = 1'b1;
        axi.rvalid  = 1'b1;
        axi.rdata   = 64'h80000000_00000000;
        apply_stimulus(1'b1, 1'b0, 32'h8000_0004, 64'h0, F3_W);
        tick();
        apply_stimulus(1'b0, 1'b0, 32'h0, 64'h0, 3'b000);
        check_output("lw_arvalid", 64'(axi.arvalid), 64'd1);
        check_output("lw_araddr", 64'(axi.araddr), 64'h8000_0000);
        check_output("lw_busy", 64'(lsu_idle), 64'd0);
        tick();
        check_output("lw_rready", 64'(axi.rready), 64'd1);
        check_output("lw_arvalid_off", 64'(axi.arvalid), 64'd0);
        tick();
        check_output("lw_r_valid", 64'(lsu_r_valid), 64'd1);
        check_output("lw_r_data", lsu_r_data, 64'hFFFFFFFF_80000000);
        check_output("lw_err", 64'(lsu_err), 64'd0);
        tick();
        check_output("lw_idle", 64'(lsu_idle), 64'd1);
        check_output("lw_r_valid_off", 64'(lsu_r_valid), 64'd0);

        // SB 0x80000003, awready held off for three cycles
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b1;
        apply_stimulus(1'b0, 1'b1, 32'h8000_0003, 64'h0000_0000_0000_00AB, F3_B);
        tick();
        apply_stimulus(1'b0, 1'b0, 32'h0, 64'h0, 3'b000);
        check_output("sb_awvalid1", 64'(axi.awvalid), 64'd1);
        check_output("sb_wvalid1", 64'(axi.wvalid), 64'd1);
        check_output("sb_wstrb", 64'(axi.wstrb), 64'h08);
        check_output("sb_wdata_byte", 64'(axi.wdata[31:24]), 64'hAB);
        tick();
        check_output("sb_awvalid2", 64'(axi.awvalid), 64'd1);
        check_output("sb_wvalid_off", 64'(axi.wvalid), 64'd0);
        tick();
        check_output("sb_awvalid3", 64'(axi.awvalid), 64'd1);
        axi.awready = 1'b1;
        tick();
        axi.awready = 1'b0;
        check_output("sb_awvalid_off", 64'(axi.awvalid), 64'd0);
        check_output("sb_bready", 64'(axi.bready), 64'd1);
        check_output("sb_no_early_ready", 64'(lsu_w_ready), 64'd0);
        axi.bvalid = 1'b1;
        axi.bresp  = RESP_OKAY;
        tick();
        axi.bvalid = 1'b0;
        check_output("sb_w_ready", 64'(lsu_w_ready), 64'd1);
        check_output("sb_err", 64'(lsu_err), 64'd0);
        check_output("sb_no_r_valid", 64'(lsu_r_valid), 64'd0);
        check_output("sb_r_data_held", lsu_r_data, 64'hFFFFFFFF_80000000);
        tick();
        check_output("sb_w_ready_off", 64'(lsu_w_ready), 64'd0);
        check_output("sb_idle", 64'(lsu_idle), 64'd1);

        // LHU 0x80000001 is misaligned and must never reach the bus
        apply_stimulus(1'b1, 1'b0, 32'h8000_0001, 64'h0, F3_HU);
        tick();
        apply_stimulus(1'b0, 1'b0, 32'h0, 64'h0, 3'b000);
        check_output("lhu_r_valid", 64'(lsu_r_valid), 64'd1);
        check_output("lhu_err", 64'(lsu_err), 64'd1);
        check_output("lhu_r_data", lsu_r_data, 64'd0);
        check_output("lhu_no_arvalid", 64'(axi.arvalid), 64'd0);
        tick();
        check_output("lhu_idle", 64'(lsu_idle), 64'd1);

        // LB 0x80000007 picks the top byte and sign-extends it
        axi.arready = 1'b1;
        axi.rvalid  = 1'b1;
        axi.rresp   = RESP_OKAY;
        axi.rdata   = 64'h80112233_44556677;
        apply_stimulus(1'b1, 1'b0, 32'h8000_0007, 64'h0, F3_B);
        tick();
        apply_stimulus(1'b0, 1'b0, 32'h0, 64'h0, 3'b000);
        tick();
        tick();
        check_output("lb_r_valid", 64'(lsu_r_valid), 64'd1);
        check_output("lb_r_data", lsu_r_data, 64'hFFFFFFFF_FFFFFF80);
        check_output("lb_err", 64'(lsu_err), 64'd0);
        tick();

        // LD with a SLVERR response
        axi.rdata = 64'h11223344_55667788;
        axi.rresp = RESP_SLVERR;
        apply_stimulus(1'b1, 1'b0, 32'h8000_0008, 64'h0, F3_D);
        tick();
        apply_stimulus(1'b0, 1'b0, 32'h0, 64'h0, 3'b000);
        check_output("ld_araddr", 64'(axi.araddr), 64'h8000_0008);
        tick();
        tick();
        check_output("ld_r_valid", 64'(lsu_r_valid), 64'd1);
        check_output("ld_err", 64'(lsu_err), 64'd1);
        check_output("ld_r_data", lsu_r_data, 64'h11223344_55667788);
        tick();
        axi.rresp = RESP_OKAY;

        // Simultaneous load and store: read wins; then reset lands in RDATA
        axi.arready = 1'b1;
        axi.rvalid  = 1'b0;
        apply_stimulus(1'b1, 1'b1, 32'h8000_0010, 64'hDEAD_BEEF, F3_D);
        tick();
        apply_stimulus(1'b0, 1'b0, 32'h0, 64'h0, 3'b000);
        check_output("both_arvalid", 64'(axi.arvalid), 64'd1);
        check_output("both_awvalid", 64'(axi.awvalid), 64'd0);
        check_output("both_wvalid", 64'(axi.wvalid), 64'd0);
        tick();
        check_output("both_rready", 64'(axi.rready), 64'd1);
        check_output("both_awvalid2", 64'(axi.awvalid), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("mid_rst_idle", 64'(lsu_idle), 64'd1);
        check_output("mid_rst_rready", 64'(axi.rready), 64'd0);
        check_output("mid_rst_r_valid", 64'(lsu_r_valid), 64'd0);
        check_output("mid_rst_r_data", lsu_r_data, 64'd0);
        tick();
        check_output("post_rst_idle", 64'(lsu_idle), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
